// File: rtl/scpu_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : scpu_cmd_sched
// Description : Sound-command FIFO plus interrupt scheduler for the Z80 sound
//               CPU. Optional periodic timer IRQ is enabled by the
//               SCPU_TIMER_IRQ_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module scpu_cmd_sched #(
    parameter logic [7:0]  CMD_PORT  = 8'h00,
    parameter logic [7:0]  STAT_PORT = 8'h01,
    parameter logic [15:0] TICK_DIV  = 16'd40000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_din,
    output logic        cmd_full,
    input  logic [15:0] scpu_ab,
    input  logic        scpu_io,
    input  logic        scpu_rd,
    input  logic        scpu_m1,
    output logic [7:0]  io_dout,
    output logic        io_sel,
    output logic        scpu_int
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    logic [7:0] r_mem [4];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_count;
    logic       r_ovf;
    logic       r_cmd_pend;
    logic       r_last_cmd;
    logic       r_rd_act;
    logic [7:0] r_rd_port;
    logic       r_src;
    logic       r_hold_low;
    state_t     r_state;

    logic       w_rd_act;
    logic       w_rd_fall;
    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic       w_ovf_clr;
    logic       w_ack;
    logic       w_tmr_pend;
    logic       w_last_tmr;
    logic       w_take_cmd;
    logic       w_take_tmr;
    logic       w_latch;
    logic       w_src_nxt;
    logic       w_hold_low_nxt;
    state_t     w_state_nxt;
    logic       w_unused_bits;

    assign w_rd_act  = scpu_io & scpu_rd & ~scpu_m1;
    assign w_rd_fall = r_rd_act & ~w_rd_act;
    assign w_ack     = scpu_io & scpu_m1;
    assign w_empty   = (r_count == 3'd0);
    assign w_full    = (r_count == 3'd4);
    assign w_push    = cmd_wr & ~w_full;
    // Side effects act on the port captured at the rise, so the head stays
    // stable for the CPU's whole read latch window.
    assign w_pop     = w_rd_fall & (r_rd_port == CMD_PORT) & ~w_empty;
    assign w_ovf_clr = w_rd_fall & (r_rd_port == STAT_PORT);
    assign cmd_full  = w_full;
    assign io_sel    = w_rd_act & ((scpu_ab[7:0] == CMD_PORT) | (scpu_ab[7:0] == STAT_PORT));
    assign w_unused_bits = ^scpu_ab[15:8];

    always_comb begin
        io_dout = 8'hFF;
        if (scpu_ab[7:0] == CMD_PORT) begin
            if (!w_empty) begin
                io_dout = r_mem[r_rptr];
            end
        end else if (scpu_ab[7:0] == STAT_PORT) begin
            io_dout = {r_ovf, w_last_tmr, r_last_cmd, r_count, w_full, w_empty};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wptr] <= cmd_din;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= 2'd0;
            r_rptr     <= 2'd0;
            r_count    <= 3'd0;
            r_ovf      <= 1'b0;
            r_cmd_pend <= 1'b0;
            r_last_cmd <= 1'b0;
            r_rd_act   <= 1'b0;
            r_rd_port  <= 8'h00;
            r_src      <= 1'b0;
            r_hold_low <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            r_rd_act <= w_rd_act;
            if (w_rd_act && !r_rd_act) begin
                r_rd_port <= scpu_ab[7:0];
            end
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (cmd_wr && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            // A new event in the same cycle as the grant stays pending.
            if (w_push) begin
                r_cmd_pend <= 1'b1;
            end else if (w_take_cmd) begin
                r_cmd_pend <= 1'b0;
            end
            if (w_latch) begin
                r_last_cmd <= ~r_src;
            end
            r_state    <= w_state_nxt;
            r_src      <= w_src_nxt;
            r_hold_low <= w_hold_low_nxt;
        end
    end

    // HOLD needs two consecutive ack-free cycles, giving a clean low gap
    // before the next rising edge on scpu_int.
    always_comb begin
        w_state_nxt    = r_state;
        w_src_nxt      = r_src;
        w_hold_low_nxt = r_hold_low;
        w_take_cmd     = 1'b0;
        w_take_tmr     = 1'b0;
        w_latch        = 1'b0;
        scpu_int       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_cmd_pend) begin
                    w_take_cmd  = 1'b1;
                    w_src_nxt   = 1'b0;
                    w_state_nxt = ST_ASSERT;
                end else if (w_tmr_pend) begin
                    w_take_tmr  = 1'b1;
                    w_src_nxt   = 1'b1;
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                scpu_int = 1'b1;
                if (w_ack) begin
                    w_latch        = 1'b1;
                    w_hold_low_nxt = 1'b0;
                    w_state_nxt    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_ack) begin
                    w_hold_low_nxt = 1'b0;
                end else if (r_hold_low) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_low_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef SCPU_TIMER_IRQ_EN
    localparam logic [15:0] c_TICK_RELOAD = TICK_DIV - 16'd1;

    logic [15:0] r_tmr_cnt;
    logic        r_tmr_pend;
    logic        r_last_tmr;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tmr_cnt  <= c_TICK_RELOAD;
            r_tmr_pend <= 1'b0;
            r_last_tmr <= 1'b0;
        end else begin
            if (r_tmr_cnt == 16'd0) begin
                r_tmr_cnt  <= c_TICK_RELOAD;
                r_tmr_pend <= 1'b1;
            end else begin
                r_tmr_cnt <= r_tmr_cnt - 16'd1;
                if (w_take_tmr) begin
                    r_tmr_pend <= 1'b0;
                end
            end
            if (w_latch) begin
                r_last_tmr <= r_src;
            end
        end
    end

    assign w_tmr_pend = r_tmr_pend;
    assign w_last_tmr = r_last_tmr;
`else
    logic w_unused_tick;

    assign w_tmr_pend    = 1'b0;
    assign w_last_tmr    = 1'b0;
    assign w_unused_tick = ^{TICK_DIV, w_take_tmr};
`endif

endmodule
`default_nettype wire

// File: tb/tb_scpu_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_scpu_cmd_sched
// Description : Self-checking bench for scpu_cmd_sched with a byte scoreboard
//               and a small status-register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scpu_cmd_sched;

    localparam logic [7:0] CMD_PORT  = 8'h00;
    localparam logic [7:0] STAT_PORT = 8'h01;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_wr  = 1'b0;
    logic [7:0]  cmd_din = 8'h00;
    logic        cmd_full;
    logic [15:0] scpu_ab = 16'h0000;
    logic        scpu_io = 1'b0;
    logic        scpu_rd = 1'b0;
    logic        scpu_m1 = 1'b0;
    logic [7:0]  io_dout;
    logic        io_sel;
    logic        scpu_int;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    logic       m_ovf;
    logic       m_last_cmd;
    logic       m_last_tmr;

    always #5 clk_sys = ~clk_sys;

    scpu_cmd_sched #(
        .CMD_PORT (CMD_PORT),
        .STAT_PORT(STAT_PORT),
        .TICK_DIV (16'd100)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .cmd_wr  (cmd_wr),
        .cmd_din (cmd_din),
        .cmd_full(cmd_full),
        .scpu_ab (scpu_ab),
        .scpu_io (scpu_io),
        .scpu_rd (scpu_rd),
        .scpu_m1 (scpu_m1),
        .io_dout (io_dout),
        .io_sel  (io_sel),
        .scpu_int(scpu_int)
    );

    function automatic logic [7:0] exp_stat();
        int n;
        n = exp_q.size();
        return {m_ovf, m_last_tmr, m_last_cmd, 3'(n), (n == 4), (n == 0)};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cmd_wr  = 1'b0;
        scpu_io = 1'b0;
        scpu_rd = 1'b0;
        scpu_m1 = 1'b0;
        scpu_ab = 16'h0000;
        exp_q.delete();
        m_ovf      = 1'b0;
        m_last_cmd = 1'b0;
        m_last_tmr = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        cmd_wr  = 1'b1;
        cmd_din = b;
        if (exp_q.size() < 4) exp_q.push_back(b);
        else m_ovf = 1'b1;
        tick();
        cmd_wr = 1'b0;
    endtask

    // Three-cycle I/O read; optionally pushes a byte in the cycle the read falls.
    task automatic io_read(input logic [7:0] port, input logic push_en, input logic [7:0] push_b,
                           output logic [7:0] d_first, output logic [7:0] d_last, output logic sel);
        scpu_ab = {8'h00, port};
        scpu_io = 1'b1;
        scpu_rd = 1'b1;
        #1;
        d_first = io_dout;
        sel     = io_sel;
        tick();
        tick();
        d_last  = io_dout;
        scpu_io = 1'b0;
        scpu_rd = 1'b0;
        if (push_en) begin
            cmd_wr  = 1'b1;
            cmd_din = push_b;
            if (exp_q.size() < 4) exp_q.push_back(push_b);
            else m_ovf = 1'b1;
        end
        tick();
        cmd_wr  = 1'b0;
        scpu_ab = 16'h0000;
    endtask

    task automatic ack_pulse(input int cycles);
        scpu_io = 1'b1;
        scpu_m1 = 1'b1;
        repeat (cycles) tick();
        scpu_io = 1'b0;
        scpu_m1 = 1'b0;
    endtask

    task automatic wait_int(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (scpu_int) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (scpu_int) ok = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d0, d1;
        logic       s;
        do_reset();
        n_checks++;
        if (scpu_int !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", scpu_int); end
        n_checks++;
        if (cmd_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", cmd_full); end
        n_checks++;
        if (io_dout !== 8'hFF || io_sel !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_bus: got dout=%h sel=%b expected dout=ff sel=0", io_dout, io_sel);
        end
        io_read(STAT_PORT, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== exp_stat() || s !== 1'b1) begin
            n_fail++; $display("FAIL reset_status: got %h sel=%b expected %h sel=1", d0, s, exp_stat());
        end
        io_read(8'h05, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== 8'hFF || s !== 1'b0) begin
            n_fail++; $display("FAIL other_port: got %h sel=%b expected ff sel=0", d0, s);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d0, d1, e;
        logic       s;
        do_reset();
        push_byte(8'h12);
        n_checks++;
        if (scpu_int !== 1'b0) begin n_fail++; $display("FAIL push_lat_n1: got %b expected 0", scpu_int); end
        tick();
        n_checks++;
        if (scpu_int !== 1'b1) begin n_fail++; $display("FAIL push_lat_n2: got %b expected 1", scpu_int); end
        ack_pulse(1);
        m_last_cmd = 1'b1;
        n_checks++;
        if (scpu_int !== 1'b0) begin n_fail++; $display("FAIL ack_drop: got %b expected 0", scpu_int); end
        io_read(STAT_PORT, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== exp_stat() || d0 !== 8'h24) begin
            n_fail++; $display("FAIL basic_status: got %h expected %h", d0, exp_stat());
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        io_read(CMD_PORT, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== e || d1 !== e || s !== 1'b1) begin
            n_fail++; $display("FAIL basic_cmd_read: got first=%h last=%h sel=%b expected %h sel=1", d0, d1, s, e);
        end
        io_read(STAT_PORT, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== exp_stat()) begin n_fail++; $display("FAIL basic_empty: got %h expected %h", d0, exp_stat()); end
    endtask

    task automatic test_overflow();
        logic [7:0] d0, d1, e;
        logic       s;
        do_reset();
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        n_checks++;
        if (cmd_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", cmd_full); end
        io_read(STAT_PORT, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== exp_stat()) begin n_fail++; $display("FAIL ovf_status_set: got %h expected %h", d0, exp_stat()); end
        m_ovf = 1'b0;
        io_read(STAT_PORT, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== exp_stat()) begin n_fail++; $display("FAIL ovf_status_clr: got %h expected %h", d0, exp_stat()); end
        for (int i = 0; i < 5; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
            io_read(CMD_PORT, 1'b0, 8'h00, d0, d1, s);
            n_checks++;
            if (d1 !== e) begin n_fail++; $display("FAIL ovf_read%0d: got %h expected %h", i, d1, e); end
        end
        n_checks++;
        if (cmd_full !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_full: got %b expected 0", cmd_full); end
    endtask

    task automatic test_push_pop();
        logic [7:0] d0, d1, e;
        logic       s;
        do_reset();
        push_byte(8'hA0);
        push_byte(8'hA1);
        e = exp_q.pop_front();
        io_read(CMD_PORT, 1'b1, 8'hA2, d0, d1, s);
        n_checks++;
        if (d1 !== e) begin n_fail++; $display("FAIL pp_head: got %h expected %h", d1, e); end
        io_read(STAT_PORT, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== exp_stat()) begin n_fail++; $display("FAIL pp_count: got %h expected %h", d0, exp_stat()); end
        for (int i = 0; i < 2; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
            io_read(CMD_PORT, 1'b0, 8'h00, d0, d1, s);
            n_checks++;
            if (d1 !== e) begin n_fail++; $display("FAIL pp_order%0d: got %h expected %h", i, d1, e); end
        end
    endtask

    task automatic test_ack_hold();
        logic ok;
        do_reset();
        push_byte(8'h33);
        wait_int(5, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_first_int: got %b expected 1", ok); end
        push_byte(8'h34);
        scpu_io = 1'b1;
        scpu_m1 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_checks++;
            if (scpu_int !== 1'b0) begin n_fail++; $display("FAIL hold_during_ack%0d: got %b expected 0", i, scpu_int); end
        end
        tick();
        scpu_io = 1'b0;
        scpu_m1 = 1'b0;
        m_last_cmd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (scpu_int !== 1'b0) begin n_fail++; $display("FAIL hold_after_drop%0d: got %b expected 0", i, scpu_int); end
            tick();
        end
        n_checks++;
        if (scpu_int !== 1'b1) begin n_fail++; $display("FAIL hold_reassert: got %b expected 1", scpu_int); end
    endtask

`ifdef SCPU_TIMER_IRQ_EN
    task automatic test_timer();
        logic [7:0] d0, d1;
        logic       s, ok, prev;
        int         rises;
        do_reset();
        rises = 0;
        prev  = scpu_int;
        for (int i = 0; i < 350; i++) begin
            tick();
            if (scpu_int && !prev) rises++;
            prev = scpu_int;
        end
        n_checks++;
        if (rises != 1 || scpu_int !== 1'b1) begin
            n_fail++; $display("FAIL tmr_coalesce: got rises=%0d int=%b expected rises=1 int=1", rises, scpu_int);
        end
        push_byte(8'h55);
        ack_pulse(1);
        m_last_tmr = 1'b1;
        m_last_cmd = 1'b0;
        wait_int(10, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL tmr_second_int: got %b expected 1", ok); end
        io_read(STAT_PORT, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== exp_stat()) begin n_fail++; $display("FAIL tmr_last_tmr: got %h expected %h", d0, exp_stat()); end
        ack_pulse(1);
        m_last_tmr = 1'b0;
        m_last_cmd = 1'b1;
        io_read(STAT_PORT, 1'b0, 8'h00, d0, d1, s);
        n_checks++;
        if (d0 !== exp_stat()) begin n_fail++; $display("FAIL tmr_cmd_priority: got %h expected %h", d0, exp_stat()); end
    endtask
`else
    task automatic test_timer();
        int hi;
        do_reset();
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (scpu_int) hi++;
        end
        n_checks++;
        if (hi != 0) begin n_fail++; $display("FAIL no_timer_int: got %0d high cycles expected 0", hi); end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        push_byte(8'h71);
        push_byte(8'h72);
        push_byte(8'h73);
        n_checks++;
        if (scpu_int !== 1'b1) begin n_fail++; $display("FAIL mid_pre_int: got %b expected 1", scpu_int); end
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        m_last_cmd = 1'b0;
        #1;
        n_checks++;
        if (scpu_int !== 1'b0 || cmd_full !== 1'b0 || io_dout !== 8'hFF) begin
            n_fail++; $display("FAIL mid_reset: got int=%b full=%b dout=%h expected int=0 full=0 dout=ff",
                               scpu_int, cmd_full, io_dout);
        end
        scpu_ab = {8'h00, STAT_PORT};
        #1;
        n_checks++;
        if (io_dout !== exp_stat()) begin n_fail++; $display("FAIL mid_reset_count: got %h expected %h", io_dout, exp_stat()); end
        scpu_ab = 16'h0000;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop();
        test_ack_hold();
        test_timer();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
